// File: rtl/alu_pkg.sv
// Shared op codes and FSM encoding for the multicycle ALU; the core decoder imports this too.
package alu_pkg;
    localparam int OLEN = 5;

    localparam logic [OLEN-1:0] OP_ADD    = 5'd0;
    localparam logic [OLEN-1:0] OP_SUB    = 5'd1;
    localparam logic [OLEN-1:0] OP_SLT    = 5'd2;
    localparam logic [OLEN-1:0] OP_SLTU   = 5'd3;
    localparam logic [OLEN-1:0] OP_AND    = 5'd4;
    localparam logic [OLEN-1:0] OP_OR     = 5'd5;
    localparam logic [OLEN-1:0] OP_XOR    = 5'd6;
    localparam logic [OLEN-1:0] OP_SL     = 5'd7;
    localparam logic [OLEN-1:0] OP_SRL    = 5'd8;
    localparam logic [OLEN-1:0] OP_SRA    = 5'd9;
    localparam logic [OLEN-1:0] OP_MUL    = 5'd10;
    localparam logic [OLEN-1:0] OP_MULH   = 5'd11;
    localparam logic [OLEN-1:0] OP_MULHSU = 5'd12;
    localparam logic [OLEN-1:0] OP_MULHU  = 5'd13;
    localparam logic [OLEN-1:0] OP_DIV    = 5'd14;
    localparam logic [OLEN-1:0] OP_DIVU   = 5'd15;
    localparam logic [OLEN-1:0] OP_REM    = 5'd16;
    localparam logic [OLEN-1:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/alu_multicycle_if.sv
// Start/done handshake and operand/result bus between the execute stage and the ALU.
interface alu_multicycle_if #(
    parameter int XLEN = 32,
    parameter int OLEN = 5
);
    logic            start;
    logic [OLEN-1:0] operation;
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (output start, operation, lhs, rhs, input busy, done, result, zero);
    modport slave  (input start, operation, lhs, rhs, output busy, done, result, zero);
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one hi:lo register pair.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            is_div,
    input  logic            step,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            last
);
    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   count;
    logic [XLEN-1:0] b_r;
    logic            div_r;
    logic [XLEN-1:0] cur_hi, cur_lo, cur_b, nx_hi, nx_lo;
    logic            cur_div;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    // The load edge already performs the first step, so the op finishes one cycle sooner.
    always_comb begin
        cur_hi    = load ? '0 : hi;
        cur_lo    = load ? a : lo;
        cur_b     = load ? b : b_r;
        cur_div   = load ? is_div : div_r;
        mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
        div_shift = {cur_hi, cur_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, cur_b};
        if (cur_div) begin
            nx_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            nx_lo = {cur_lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            {nx_hi, nx_lo} = {mul_sum, cur_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            b_r   <= '0;
            div_r <= 1'b0;
        end else begin
            if (load) begin
                b_r   <= b;
                div_r <= is_div;
            end
            if (load || (step && count != '0)) begin
                hi    <= nx_hi;
                lo    <= nx_lo;
                count <= load ? CW'(XLEN - 1) : count - CW'(1);
            end
        end
    end

    assign last = (count == CW'(1));
endmodule

// File: rtl/alu_multicycle.sv
// Sequential RV32IM ALU: single-cycle base ops, iterative MUL/DIV, registered result and done pulse.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SBITS = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    alu_multicycle_if.slave bus
);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nx;
    logic [OLEN-1:0] op_r;
    logic            neg_q, neg_r;
    logic            accept, mul_op, div_op, rem_op, sgn_div, lhs_s, rhs_s;
    logic            a_neg, b_neg, div_zero, div_ovf, special, load, step, last;
    logic [XLEN-1:0] a_mag, b_mag, base_res, special_res, now_res, fin_res, hi, lo;
    logic [2*XLEN-1:0] prod_fix;

    assign accept  = bus.start && (state == ST_IDLE);
    assign mul_op  = (bus.operation >= OP_MUL) && (bus.operation <= OP_MULHU);
    assign div_op  = (bus.operation >= OP_DIV) && (bus.operation <= OP_REMU);
    assign rem_op  = (bus.operation == OP_REM) || (bus.operation == OP_REMU);
    assign sgn_div = (bus.operation == OP_DIV) || (bus.operation == OP_REM);
    assign lhs_s   = sgn_div || (bus.operation == OP_MUL) || (bus.operation == OP_MULH)
                     || (bus.operation == OP_MULHSU);
    assign rhs_s   = sgn_div || (bus.operation == OP_MUL) || (bus.operation == OP_MULH);
    assign a_neg   = lhs_s && bus.lhs[XLEN-1];
    assign b_neg   = rhs_s && bus.rhs[XLEN-1];
    assign a_mag   = a_neg ? -bus.lhs : bus.lhs;
    assign b_mag   = b_neg ? -bus.rhs : bus.rhs;

    assign div_zero    = (bus.rhs == '0);
    assign div_ovf     = sgn_div && (bus.lhs == MOST_NEG) && (bus.rhs == '1);
    assign special     = div_op && (div_zero || div_ovf);
    assign special_res = div_zero ? (rem_op ? bus.lhs : '1) : (rem_op ? '0 : bus.lhs);
    assign load        = accept && (mul_op || (div_op && !special));

    always_comb begin
        case (bus.operation)
            OP_SUB:  base_res = bus.lhs - bus.rhs;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(bus.lhs) < $signed(bus.rhs)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, bus.lhs < bus.rhs};
            OP_AND:  base_res = bus.lhs & bus.rhs;
            OP_OR:   base_res = bus.lhs | bus.rhs;
            OP_XOR:  base_res = bus.lhs ^ bus.rhs;
            OP_SL:   base_res = bus.lhs << bus.rhs[SBITS-1:0];
            OP_SRL:  base_res = bus.lhs >> bus.rhs[SBITS-1:0];
            OP_SRA:  base_res = $signed(bus.lhs) >>> bus.rhs[SBITS-1:0];
            default: base_res = bus.lhs + bus.rhs;
        endcase
        now_res = div_op ? special_res : base_res;
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .is_div (div_op),
        .step   (step),
        .a      (a_mag),
        .b      (b_mag),
        .hi     (hi),
        .lo     (lo),
        .last   (last)
    );

    // Magnitudes were iterated; restore signs before picking the result word.
    always_comb begin
        prod_fix = neg_q ? -{hi, lo} : {hi, lo};
        case (op_r)
            OP_MUL:                      fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fin_res = neg_q ? -lo : lo;
            default:                     fin_res = neg_r ? -hi : hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (load) state_nx = mul_op ? ST_MUL : ST_DIV;
            ST_MUL:  if (last) state_nx = ST_FIN;
            ST_DIV:  if (last) state_nx = ST_FIN;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != ST_IDLE);
        step     = (state == ST_MUL) || (state == ST_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.result <= '0;
            bus.zero   <= 1'b1;
            bus.done   <= 1'b0;
            op_r       <= OP_ADD;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                op_r  <= bus.operation;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (!load) begin
                    bus.result <= now_res;
                    bus.zero   <= (now_res == '0);
                    bus.done   <= 1'b1;
                end
            end
            if (state == ST_FIN) begin
                bus.result <= fin_res;
                bus.zero   <= (fin_res == '0);
                bus.done   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench: arithmetic reference model with cycle-level done/busy/result tracking.
module tb_alu_multicycle;
    import alu_pkg::*;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_multicycle_if #(.XLEN(XLEN), .OLEN(OLEN)) bus ();
    alu_multicycle #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        logic [4:0] sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        sh = b[4:0];
        case (op)
            OP_SUB:    return a - b;
            OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_SL:     return a << sh;
            OP_SRL:    return a >> sh;
            OP_SRA:    begin p = 64'(sa >>> sh); return p[31:0]; end
            OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV:    begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
            OP_DIVU:   begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            OP_REM:    begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
            OP_REMU:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
            default:   return a + b;
        endcase
    endfunction

    function automatic int lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= OP_MUL && op <= OP_MULHU) return 33;
        if (op >= OP_DIV && op <= OP_REMU) begin
            if (b == 0) return 1;
            if ((op == OP_DIV || op == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    // Reference state for the cycle following each rising edge.
    bit          live = 0;
    bit          pend = 0;
    int          pend_due = 0;
    logic [31:0] pend_val = '0;
    int          edge_n = 0;
    logic        exp_done = 1'b0, exp_busy = 1'b0, exp_zero = 1'b1;
    logic [31:0] exp_res = '0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            live = 1;
            pend = 0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
            exp_res = '0;
            exp_zero = 1'b1;
        end else if (live) begin
            if (bus.start && !(pend && pend_due >= edge_n)) begin
                pend = 1;
                pend_val = model(bus.operation, bus.lhs, bus.rhs);
                pend_due = edge_n + lat(bus.operation, bus.lhs, bus.rhs) - 1;
            end
            exp_done = pend && (pend_due == edge_n);
            exp_busy = pend && (pend_due > edge_n);
            if (exp_done) begin
                exp_res = pend_val;
                exp_zero = (pend_val == 0);
                pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("done", {63'h0, bus.done}, {63'h0, exp_done});
            check("busy", {63'h0, bus.busy}, {63'h0, exp_busy});
            check("result", {32'h0, bus.result}, {32'h0, exp_res});
            check("zero", {63'h0, bus.zero}, {63'h0, exp_zero});
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int exp_lat);
        int n;
        check({"model_", name}, {32'h0, model(op, a, b)}, {32'h0, lit});
        bus.start = 1'b1;
        bus.operation = op;
        bus.lhs = a;
        bus.rhs = b;
        n = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end while (!bus.done && n < 100);
        check({"lat_", name}, 64'(n), 64'(exp_lat));
        check({"res_", name}, {32'h0, bus.result}, {32'h0, lit});
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.operation = OP_ADD;
        bus.lhs = '0;
        bus.rhs = '0;
        repeat (2) @(negedge clk);
        check("reset_result", {32'h0, bus.result}, 64'h0);
        check("reset_zero", {63'h0, bus.zero}, 64'h1);
        reset = 1'b0;

        run_op("add", OP_ADD, 5, 7, 12, 1);
        check("add_zero", {63'h0, bus.zero}, 64'h0);
        check("add_busy", {63'h0, bus.busy}, 64'h0);

        // SUB then SRA back-to-back: done on two consecutive cycles
        bus.start = 1'b1; bus.operation = OP_SUB; bus.lhs = 3; bus.rhs = 3;
        @(negedge clk);
        check("b2b_done1", {63'h0, bus.done}, 64'h1);
        check("b2b_res1", {32'h0, bus.result}, 64'h0);
        check("b2b_zero1", {63'h0, bus.zero}, 64'h1);
        bus.operation = OP_SRA; bus.lhs = 32'h80000000; bus.rhs = 4;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_done2", {63'h0, bus.done}, 64'h1);
        check("b2b_res2", {32'h0, bus.result}, 64'hF8000000);
        @(negedge clk);

        run_op("slt", OP_SLT, 32'hFFFFFFFF, 1, 1, 1);
        run_op("sltu", OP_SLTU, 32'hFFFFFFFF, 1, 0, 1);
        run_op("and", OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
        run_op("or", OP_OR, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1);
        run_op("xor", OP_XOR, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
        run_op("sl", OP_SL, 1, 33, 2, 1);
        run_op("srl", OP_SRL, 32'h80000000, 4, 32'h08000000, 1);
        run_op("op20", 5'd20, 1, 2, 3, 1);

        run_op("mulh", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33);
        run_op("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mul", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 33);
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 33);

        run_op("div", OP_DIV, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 33);
        run_op("rem", OP_REM, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 33);
        run_op("divu", OP_DIVU, 100, 7, 14, 33);
        run_op("remu", OP_REMU, 100, 7, 2, 33);

        run_op("div0", OP_DIV, 5, 0, 32'hFFFFFFFF, 1);
        run_op("rem0", OP_REM, 5, 0, 5, 1);
        run_op("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("removf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 0, 1);

        // MUL with a stray start and operand changes mid-flight
        bus.start = 1'b1; bus.operation = OP_MUL; bus.lhs = 3; bus.rhs = 5;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (n == 10) begin
                bus.start = 1'b1; bus.operation = OP_ADD; bus.lhs = 100; bus.rhs = 200;
            end
            if (n == 11) bus.start = 1'b0;
        end while (!bus.done && n < 100);
        check("ignore_lat", 64'(n), 64'd33);
        check("ignore_res", {32'h0, bus.result}, 64'd15);
        @(negedge clk);

        // Reset mid-MUL aborts without a done
        bus.start = 1'b1; bus.operation = OP_MUL; bus.lhs = 7; bus.rhs = 9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'h0, bus.busy}, 64'h0);
        check("abort_done", {63'h0, bus.done}, 64'h0);
        check("abort_result", {32'h0, bus.result}, 64'h0);
        repeat (30) @(negedge clk);
        run_op("add_after", OP_ADD, 2, 2, 4, 1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
